reg_file_sb: RTL and testbench

//  Parametrised MIPS register file for the project datapath: NUM_REGS x DATA_W storage,
//  two combinational read ports, one clocked write port. Register 0 optionally hardwired to 0.

---
 rtl/reg_file_sb_if.sv | 33 +++
 rtl/reg_file_sb.sv | 114 +++++++++++
 tb/tb_reg_file_sb.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - read/write/scoreboard bus bundle for the register file
// Signals:
//   rr1, rr2   read addresses          rd1, rd2    read data
//   regwrite   write enable            wr, wd      write address / data
//   issue      mark destination busy   issue_reg   destination register
//   busy1/2    pending-result flags for rr1/rr2
// master drives addresses, write and issue; slave (the register file) returns data and busy flags.
interface reg_file_sb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
);
    logic [ADDR_W-1:0] rr1;
    logic [ADDR_W-1:0] rr2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              regwrite;
    logic [ADDR_W-1:0] wr;
    logic [DATA_W-1:0] wd;
    logic              issue;
    logic [ADDR_W-1:0] issue_reg;
    logic              busy1;
    logic              busy2;

    modport master (
        output rr1, rr2, regwrite, wr, wd, issue, issue_reg,
        input  rd1, rd2, busy1, busy2
    );

    modport slave (
        input  rr1, rr2, regwrite, wr, wd, issue, issue_reg,
        output rd1, rd2, busy1, busy2
    );
endinterface

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - MIPS register file with write bypass and RAW busy scoreboard
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset; clears storage and busy bits
//   bus      reg_file_sb_if.slave: two combinational read ports, one clocked write port,
//            issue/writeback scoreboard with per-read-port busy flags
module reg_file_sb #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2,
    parameter int ZERO_R0  = 1,
    parameter int BYPASS   = 1
) (
    input  logic          clock,
    input  logic          reset_n,
    reg_file_sb_if.slave  bus
);

    localparam bit ZERO_EN   = (ZERO_R0 != 0);
    localparam bit BYPASS_EN = (BYPASS != 0);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // A write that will actually land in storage. Gating with reset_n keeps the
    // bypass path from exposing write data while the file is held in reset.
    logic wr_ok;
    assign wr_ok = bus.regwrite && reset_n && !(ZERO_EN && (bus.wr == '0));

    always_comb begin
        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[bus.wr] = bus.wd;
        end
    end

    // Writeback clears before issue sets, so a same-edge issue to the same
    // register leaves it busy: the newly issued producer is still outstanding.
    always_comb begin
        busy_d = busy_q;
        if (bus.regwrite) begin
            busy_d[bus.wr] = 1'b0;
        end
        if (bus.issue) begin
            busy_d[bus.issue_reg] = 1'b1;
        end
        if (ZERO_EN) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    logic [DATA_W-1:0] rd1_c;
    logic [DATA_W-1:0] rd2_c;
    logic              busy1_c;
    logic              busy2_c;

    always_comb begin
        rd1_c = regs_q[bus.rr1];
        if (BYPASS_EN && wr_ok && (bus.wr == bus.rr1)) begin
            rd1_c = bus.wd;
        end
        if (ZERO_EN && (bus.rr1 == '0)) begin
            rd1_c = '0;
        end
    end

    always_comb begin
        rd2_c = regs_q[bus.rr2];
        if (BYPASS_EN && wr_ok && (bus.wr == bus.rr2)) begin
            rd2_c = bus.wd;
        end
        if (ZERO_EN && (bus.rr2 == '0)) begin
            rd2_c = '0;
        end
    end

    // With bypass, a writeback landing this cycle already satisfies the reader,
    // unless a new producer for the same register issues at the same edge.
    always_comb begin
        busy1_c = busy_q[bus.rr1];
        if (BYPASS_EN && bus.regwrite && (bus.wr == bus.rr1) &&
            !(bus.issue && (bus.issue_reg == bus.rr1))) begin
            busy1_c = 1'b0;
        end
    end

    always_comb begin
        busy2_c = busy_q[bus.rr2];
        if (BYPASS_EN && bus.regwrite && (bus.wr == bus.rr2) &&
            !(bus.issue && (bus.issue_reg == bus.rr2))) begin
            busy2_c = 1'b0;
        end
    end

    assign bus.rd1   = rd1_c;
    assign bus.rd2   = rd2_c;
    assign bus.busy1 = busy1_c;
    assign bus.busy2 = busy2_c;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed table-driven bench for reg_file_sb (default and wide/no-bypass)
module tb_reg_file_sb;

    logic clock;
    logic reset_n;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    reg_file_sb_if #(.DATA_W(16), .ADDR_W(2)) bn ();
    reg_file_sb_if #(.DATA_W(32), .ADDR_W(3)) bw ();

    reg_file_sb #(
        .DATA_W(16), .NUM_REGS(4), .ADDR_W(2), .ZERO_R0(1), .BYPASS(1)
    ) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bn)
    );

    reg_file_sb #(
        .DATA_W(32), .NUM_REGS(8), .ADDR_W(3), .ZERO_R0(1), .BYPASS(0)
    ) u_dut_w (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bw)
    );

    typedef struct {
        logic [1:0]  rr1;
        logic [1:0]  rr2;
        logic        we;
        logic [1:0]  wr;
        logic [15:0] wd;
        logic        iss;
        logic [1:0]  ir;
        logic [15:0] e_rd1;
        logic [15:0] e_rd2;
        logic        e_b1;
        logic        e_b2;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic vec_t mk(
        input logic [1:0] rr1, input logic [1:0] rr2,
        input logic we, input logic [1:0] wr, input logic [15:0] wd,
        input logic iss, input logic [1:0] ir,
        input logic [15:0] e_rd1, input logic [15:0] e_rd2,
        input logic e_b1, input logic e_b2);
        vec_t v;
        v.rr1 = rr1; v.rr2 = rr2; v.we = we; v.wr = wr; v.wd = wd;
        v.iss = iss; v.ir = ir;
        v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_b1 = e_b1; v.e_b2 = e_b2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_n();
        bn.regwrite = 1'b0; bn.wr = '0; bn.wd = '0;
        bn.issue = 1'b0; bn.issue_reg = '0;
    endtask

    task automatic idle_w();
        bw.regwrite = 1'b0; bw.wr = '0; bw.wd = '0;
        bw.issue = 1'b0; bw.issue_reg = '0;
    endtask

    initial begin
        //               rr1 rr2 we wr wd        iss ir  rd1       rd2       b1 b2
        vecs[0]  = mk(0, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0);
        vecs[1]  = mk(2, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0);
        vecs[2]  = mk(1, 2, 1, 1, 16'h1234, 0, 0, 16'h1234, 16'h0000, 0, 0);
        vecs[3]  = mk(1, 3, 1, 3, 16'hFFFF, 0, 0, 16'h1234, 16'hFFFF, 0, 0);
        vecs[4]  = mk(1, 3, 0, 0, 16'h0000, 0, 0, 16'h1234, 16'hFFFF, 0, 0);
        vecs[5]  = mk(0, 0, 1, 0, 16'hAAAA, 0, 0, 16'h0000, 16'h0000, 0, 0);
        vecs[6]  = mk(0, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h1234, 0, 0);
        vecs[7]  = mk(0, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h1234, 0, 0);
        vecs[8]  = mk(1, 1, 1, 1, 16'h0001, 0, 0, 16'h0001, 16'h0001, 0, 0);
        vecs[9]  = mk(1, 2, 1, 1, 16'h00FF, 0, 0, 16'h00FF, 16'h0000, 0, 0);
        vecs[10] = mk(1, 1, 0, 0, 16'h0000, 0, 0, 16'h00FF, 16'h00FF, 0, 0);
        vecs[11] = mk(2, 3, 0, 0, 16'h0000, 1, 2, 16'h0000, 16'hFFFF, 0, 0);
        vecs[12] = mk(2, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'hFFFF, 1, 0);
        vecs[13] = mk(2, 3, 0, 1, 16'h5555, 0, 3, 16'h0000, 16'hFFFF, 1, 0);
        vecs[14] = mk(2, 2, 1, 2, 16'h2222, 0, 0, 16'h2222, 16'h2222, 0, 0);
        vecs[15] = mk(2, 3, 0, 0, 16'h0000, 0, 0, 16'h2222, 16'hFFFF, 0, 0);
        vecs[16] = mk(3, 1, 1, 3, 16'h3333, 1, 3, 16'h3333, 16'h00FF, 0, 0);
        vecs[17] = mk(3, 3, 0, 0, 16'h0000, 0, 0, 16'h3333, 16'h3333, 1, 1);
        vecs[18] = mk(3, 2, 0, 0, 16'h0000, 1, 3, 16'h3333, 16'h2222, 1, 0);
        vecs[19] = mk(3, 2, 0, 0, 16'h0000, 0, 0, 16'h3333, 16'h2222, 1, 0);
        vecs[20] = mk(1, 3, 1, 1, 16'h0101, 0, 0, 16'h0101, 16'h3333, 0, 1);
        vecs[21] = mk(1, 3, 0, 0, 16'h0000, 0, 0, 16'h0101, 16'h3333, 0, 1);
        vecs[22] = mk(3, 3, 1, 3, 16'h4444, 0, 0, 16'h4444, 16'h4444, 0, 0);
        vecs[23] = mk(3, 1, 0, 0, 16'h0000, 0, 0, 16'h4444, 16'h0101, 0, 0);
        vecs[24] = mk(0, 1, 0, 0, 16'h5555, 0, 0, 16'h0000, 16'h0101, 0, 0);
        vecs[25] = mk(1, 2, 0, 1, 16'h5555, 0, 1, 16'h0101, 16'h2222, 0, 0);
        vecs[26] = mk(2, 3, 0, 2, 16'h5555, 0, 2, 16'h2222, 16'h4444, 0, 0);
        vecs[27] = mk(3, 0, 0, 3, 16'h5555, 0, 3, 16'h4444, 16'h0000, 0, 0);
        vecs[28] = mk(1, 3, 0, 0, 16'h0000, 0, 0, 16'h0101, 16'h4444, 0, 0);

        reset_n = 1'b0;
        idle_n(); bn.rr1 = '0; bn.rr2 = '0;
        idle_w(); bw.rr1 = '0; bw.rr2 = '0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // One vector per cycle: drive after the falling edge, check the combinational
        // outputs, and let the next rising edge commit any write/issue.
        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            bn.rr1 = vecs[i].rr1; bn.rr2 = vecs[i].rr2;
            bn.regwrite = vecs[i].we; bn.wr = vecs[i].wr; bn.wd = vecs[i].wd;
            bn.issue = vecs[i].iss; bn.issue_reg = vecs[i].ir;
            #1;
            check($sformatf("v%0d rd1", i),   32'(bn.rd1),   32'(vecs[i].e_rd1));
            check($sformatf("v%0d rd2", i),   32'(bn.rd2),   32'(vecs[i].e_rd2));
            check($sformatf("v%0d busy1", i), 32'(bn.busy1), 32'(vecs[i].e_b1));
            check($sformatf("v%0d busy2", i), 32'(bn.busy2), 32'(vecs[i].e_b2));
        end

        // Asynchronous reset between edges, writes/issues ignored while held.
        @(negedge clock);
        bn.regwrite = 1'b1; bn.wr = 2'd2; bn.wd = 16'hBEEF;
        bn.issue = 1'b1; bn.issue_reg = 2'd1;
        bn.rr1 = 2'd2; bn.rr2 = 2'd1;
        @(negedge clock);
        idle_n();
        #1;
        check("rst pre rd1",   32'(bn.rd1),   32'h0000_BEEF);
        check("rst pre busy2", 32'(bn.busy2), 32'h1);
        #1 reset_n = 1'b0;
        #1;
        check("rst async rd1",   32'(bn.rd1),   32'h0);
        check("rst async busy2", 32'(bn.busy2), 32'h0);
        bn.regwrite = 1'b1; bn.wr = 2'd2; bn.wd = 16'h1111;
        bn.issue = 1'b1; bn.issue_reg = 2'd1;
        @(posedge clock);
        #1;
        check("rst held rd1",   32'(bn.rd1),   32'h0);
        check("rst held busy2", 32'(bn.busy2), 32'h0);
        @(negedge clock);
        idle_n();
        reset_n = 1'b1;
        #1;
        check("rst after rd1",   32'(bn.rd1),   32'h0);
        check("rst after busy2", 32'(bn.busy2), 32'h0);

        // Wide, no-bypass instance.
        @(negedge clock);
        idle_w(); bw.rr1 = 3'd7; bw.rr2 = 3'd0;
        #1;
        check("w reset rd1",   32'(bw.rd1),   32'h0);
        check("w reset busy1", 32'(bw.busy1), 32'h0);
        bw.regwrite = 1'b1; bw.wr = 3'd1; bw.wd = 32'h0000_1234; bw.rr1 = 3'd1;
        #1;
        check("w nobyp rd1", 32'(bw.rd1), 32'h0);
        @(negedge clock);
        bw.wr = 3'd7; bw.wd = 32'hFFFF_FFFF; bw.rr2 = 3'd7;
        #1;
        check("w wr rd1",    32'(bw.rd1), 32'h0000_1234);
        check("w nobyp rd2", 32'(bw.rd2), 32'h0);
        @(negedge clock);
        bw.regwrite = 1'b0;
        #1;
        check("w wr rd2", 32'(bw.rd2), 32'hFFFF_FFFF);

        bw.regwrite = 1'b1; bw.wr = 3'd0; bw.wd = 32'hAAAA_AAAA;
        @(negedge clock);
        bw.regwrite = 1'b0; bw.issue = 1'b1; bw.issue_reg = 3'd0;
        @(negedge clock);
        idle_w(); bw.rr1 = 3'd0;
        #1;
        check("w r0 rd1",   32'(bw.rd1),   32'h0);
        check("w r0 busy1", 32'(bw.busy1), 32'h0);

        bw.regwrite = 1'b1; bw.wr = 3'd1; bw.wd = 32'h0000_0001;
        @(negedge clock);
        bw.wd = 32'h0000_00FF; bw.rr1 = 3'd1;
        #1;
        check("w old rd1", 32'(bw.rd1), 32'h0000_0001);
        @(negedge clock);
        bw.regwrite = 1'b0;
        #1;
        check("w new rd1", 32'(bw.rd1), 32'h0000_00FF);

        bw.issue = 1'b1; bw.issue_reg = 3'd5; bw.rr1 = 3'd5;
        #1;
        check("w sb pre busy1", 32'(bw.busy1), 32'h0);
        @(negedge clock);
        bw.issue = 1'b0;
        #1;
        check("w sb k busy1", 32'(bw.busy1), 32'h1);
        @(negedge clock);
        @(negedge clock);
        bw.regwrite = 1'b1; bw.wr = 3'd5; bw.wd = 32'h0000_0055;
        #1;
        check("w sb wb busy1", 32'(bw.busy1), 32'h1);
        check("w sb wb rd1",   32'(bw.rd1),   32'h0);
        @(negedge clock);
        bw.regwrite = 1'b0;
        #1;
        check("w sb clr busy1", 32'(bw.busy1), 32'h0);
        check("w sb clr rd1",   32'(bw.rd1),   32'h0000_0055);

        bw.regwrite = 1'b1; bw.wr = 3'd6; bw.wd = 32'h0000_0066;
        bw.issue = 1'b1; bw.issue_reg = 3'd6; bw.rr2 = 3'd6;
        @(negedge clock);
        idle_w();
        #1;
        check("w same busy2", 32'(bw.busy2), 32'h1);
        check("w same rd2",   32'(bw.rd2),   32'h0000_0066);

        for (int a = 0; a < 4; a++) begin
            @(negedge clock);
            bw.regwrite = 1'b0; bw.wr = 3'(a * 2 + 1); bw.wd = 32'h5555_5555;
        end
        @(negedge clock);
        idle_w(); bw.rr1 = 3'd1; bw.rr2 = 3'd7;
        #1;
        check("w hold rd1", 32'(bw.rd1), 32'h0000_00FF);
        check("w hold rd2", 32'(bw.rd2), 32'hFFFF_FFFF);

        bw.rr1 = 3'd7; bw.rr2 = 3'd6;
        #1 reset_n = 1'b0;
        #1;
        check("w rst rd1",   32'(bw.rd1),   32'h0);
        check("w rst busy2", 32'(bw.busy2), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
